// File: rtl/pong_score_ctrl.sv
// Game control and scoring for the pong board: input conditioning, game FSM,
// lives, a 4-digit BCD score and the multiplexed 7-segment scan.
module pong_score_ctrl #(
  parameter int INIT_LIVES   = 3,
  parameter int SCORE_FRAMES = 60,
  parameter int MISS_FRAMES  = 120,
  parameter int DEB_CYCLES   = 1000000,
  parameter int REFRESH_DIV  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vs,
  input  logic       lose,
  input  logic       btn_start,
  output logic       play,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int FW = $clog2(SCORE_FRAMES + 1);
  localparam int MW = $clog2(MISS_FRAMES + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(REFRESH_DIV + 1);

  typedef enum logic [2:0] {IDLE, PLAY, PAUSE, MISS, OVER} state_t;

  state_t         state_reg;
  logic [15:0]    score_reg;
  logic [FW-1:0]  frame_cnt_reg;
  logic [MW-1:0]  miss_cnt_reg;

  // Synchronizer bits are packed {btn_start, lose, vs}; idle levels are 0,0,1.
  logic [2:0]     sync1_reg, sync2_reg;
  logic           vs_prev_reg, lose_prev_reg;
  logic           frame_tick, lose_rise;

  logic           deb_level_reg, deb_prev_reg, btn_press;
  logic [DW-1:0]  deb_cnt_reg;

  logic [RW-1:0]  refresh_cnt_reg;
  logic [1:0]     digit_idx_reg;
  logic [3:0]     cur_digit;
  logic [7:0]     cur_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg     <= 3'b001;
      sync2_reg     <= 3'b001;
      vs_prev_reg   <= 1'b1;
      lose_prev_reg <= 1'b0;
      frame_tick    <= 1'b0;
      lose_rise     <= 1'b0;
    end else begin
      sync1_reg     <= {btn_start, lose, vs};
      sync2_reg     <= sync1_reg;
      vs_prev_reg   <= sync2_reg[0];
      lose_prev_reg <= sync2_reg[1];
      frame_tick    <= vs_prev_reg & ~sync2_reg[0];
      lose_rise     <= ~lose_prev_reg & sync2_reg[1];
    end
  end

  // Level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_level_reg <= 1'b0;
      deb_prev_reg  <= 1'b0;
      deb_cnt_reg   <= '0;
      btn_press     <= 1'b0;
    end else begin
      if (sync2_reg[2] != deb_level_reg) begin
        if (deb_cnt_reg == DW'(DEB_CYCLES - 1)) begin
          deb_level_reg <= sync2_reg[2];
          deb_cnt_reg   <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end else begin
        deb_cnt_reg <= '0;
      end
      deb_prev_reg <= deb_level_reg;
      btn_press    <= deb_level_reg & ~deb_prev_reg;
    end
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (s == 16'h9999) r = s;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      score_reg     <= '0;
      frame_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      lives         <= 2'(INIT_LIVES);
      play          <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          score_reg     <= '0;
          frame_cnt_reg <= '0;
          lives         <= 2'(INIT_LIVES);
          if (btn_press) begin
            state_reg <= PLAY;
            play      <= 1'b1;
          end
        end
        PLAY: begin
          if (lose_rise) begin
            lives <= lives - 2'd1;
            play  <= 1'b0;
            if (lives == 2'd1) begin
              state_reg <= OVER;
              game_over <= 1'b1;
            end else begin
              state_reg    <= MISS;
              miss_cnt_reg <= '0;
            end
          end else if (btn_press) begin
            state_reg <= PAUSE;
            play      <= 1'b0;
          end else if (frame_tick) begin
            if (frame_cnt_reg == FW'(SCORE_FRAMES - 1)) begin
              frame_cnt_reg <= '0;
              score_reg     <= bcd_inc(score_reg);
            end else begin
              frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (btn_press) begin
            state_reg <= PLAY;
            play      <= 1'b1;
          end
        end
        MISS: begin
          if (frame_tick) begin
            if (miss_cnt_reg == MW'(MISS_FRAMES - 1)) begin
              miss_cnt_reg <= '0;
              state_reg    <= PLAY;
              play         <= 1'b1;
            end else begin
              miss_cnt_reg <= miss_cnt_reg + 1'b1;
            end
          end
        end
        OVER: begin
          if (btn_press) begin
            state_reg     <= IDLE;
            game_over     <= 1'b0;
            lives         <= 2'(INIT_LIVES);
            score_reg     <= '0;
            frame_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          play      <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [7:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign cur_digit = score_reg[{digit_idx_reg, 2'b00} +: 4];

  always_comb begin
    cur_seg = seg_pattern(cur_digit);
    if (game_over && digit_idx_reg == 2'd0) cur_seg[7] = 1'b0;
  end

  // an and seg load on the same edge so a digit never shows another's pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_reg <= '0;
      digit_idx_reg   <= 2'd0;
      an              <= 4'hF;
      seg             <= 8'hFF;
    end else if (refresh_cnt_reg == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt_reg <= '0;
      digit_idx_reg   <= digit_idx_reg + 2'd1;
      an              <= ~(4'b0001 << digit_idx_reg);
      seg             <= cur_seg;
    end else begin
      refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
    end
  end

endmodule
